// File: rtl/gsim_band_solver.sv
`timescale 1ns/1ps
// gsim_band_solver: Gauss-Seidel solver for the 7-band symmetric Toeplitz system
// (diag 20, off-diagonals -13 / 6 / -1). The block collects N b samples, runs ITER
// in-place sweeps from x = 0, then streams N Q(XW-FRAC).FRAC x values with backpressure.
// Each x update takes L = 2 cycles: one cycle forms the banded sum S + 10, and the
// next cycle does the floor division by 20, saturation and write-back.
// Optional feature macro: GSIM_EARLY_STOP_EN. When it is defined, a sweep that
// changes no x value ends SOLVE early, and the iters_used port reports the number
// of sweeps run.
module gsim_band_solver #(
  parameter int N    = 16,
  parameter int BW   = 16,
  parameter int XW   = 32,
  parameter int FRAC = 16,
  parameter int ITER = 70,
  parameter int GW   = XW + 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_en,
  input  logic signed [BW-1:0] b_in,
  output logic                 in_ready,
  output logic                 busy,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic signed [XW-1:0] x_out
`ifdef GSIM_EARLY_STOP_EN
  , output logic [15:0]        iters_used
`endif
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] I_LAST = IW'(N - 1);
  localparam logic [15:0]   K_LAST = 16'(ITER - 1);
  localparam logic signed [GW-1:0] C_ROUND = GW'(10);
  localparam logic signed [GW-1:0] C_DIV   = GW'(20);
  localparam logic signed [GW-1:0] C_ONE   = GW'(1);
  localparam logic signed [XW-1:0] XO_MAX  = {1'b0, {(XW-1){1'b1}}};
  localparam logic signed [XW-1:0] XO_MIN  = {1'b1, {(XW-1){1'b0}}};
  localparam logic signed [GW-1:0] XQ_MAX  = GW'(XO_MAX);
  localparam logic signed [GW-1:0] XQ_MIN  = GW'(XO_MIN);

  typedef enum logic [1:0] {ST_RECV, ST_SOLVE, ST_SEND} state_t;

  state_t                r_state;
  logic [IW-1:0]         r_idx;
  logic [15:0]           r_sweep;
  logic                  r_phase;
  logic signed [GW-1:0]  r_t;
  logic                  r_in_ready;
  logic                  r_busy;
  logic                  r_out_valid;
  logic signed [XW-1:0]  r_x_out;
  logic signed [BW-1:0]  r_b_mem [N];
  logic signed [XW-1:0]  r_x_mem [N];
`ifdef GSIM_EARLY_STOP_EN
  logic                  r_changed;
  logic [15:0]           r_iters_used;
`endif

  // Neighbours x[i-3..i-1] and x[i+1..i+3], sign-extended; out-of-range taps read 0.
  logic signed [GW-1:0] w_nb [6];
  for (genvar gi = 0; gi < 6; gi++) begin : g_nb
    localparam int OFF = (gi < 3) ? gi - 3 : gi - 2;
    int w_j;
    assign w_j = int'({1'b0, r_idx}) + OFF;
    assign w_nb[gi] = (w_j >= 0 && w_j < N)
                    ? {{(GW-XW){r_x_mem[w_j[IW-1:0]][XW-1]}}, r_x_mem[w_j[IW-1:0]]}
                    : '0;
  end

  logic signed [BW-1:0] w_b_cur;
  logic signed [GW-1:0] w_b_ext, w_p1, w_p2, w_p3, w_s;
  assign w_b_cur = r_b_mem[r_idx];
  assign w_b_ext = {{(GW-BW){w_b_cur[BW-1]}}, w_b_cur} <<< FRAC;
  assign w_p1    = w_nb[2] + w_nb[3];
  assign w_p2    = w_nb[1] + w_nb[4];
  assign w_p3    = w_nb[0] + w_nb[5];
  // 13*p1 - 6*p2 + p3 as shift-adds; GW leaves ample headroom so nothing wraps
  assign w_s = w_b_ext + (w_p1 <<< 3) + (w_p1 <<< 2) + w_p1
             - (w_p2 <<< 2) - (w_p2 <<< 1) + w_p3;

  // Floor division of (S + 10) by 20: truncating divide, then step down for negative inexact results
  logic signed [GW-1:0] w_q, w_r, w_qf;
  logic signed [XW-1:0] w_x_new;
  assign w_q  = r_t / C_DIV;
  assign w_r  = r_t % C_DIV;
  assign w_qf = (r_t[GW-1] && (w_r != '0)) ? (w_q - C_ONE) : w_q;

  // Saturate the quotient into the signed XW range before storage
  always_comb begin
    w_x_new = w_qf[XW-1:0];
    if (w_qf > XQ_MAX) begin
      w_x_new = XO_MAX;
    end else if (w_qf < XQ_MIN) begin
      w_x_new = XO_MIN;
    end
  end

  logic w_converged;
`ifdef GSIM_EARLY_STOP_EN
  assign w_converged = !r_changed && (w_x_new == r_x_mem[r_idx]);
  assign iters_used  = r_iters_used;
`else
  assign w_converged = 1'b0;
`endif

  // Control FSM: receive b, sweep x in place, stream x out under backpressure
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_RECV;
      r_idx       <= '0;
      r_sweep     <= '0;
      r_phase     <= 1'b0;
      r_t         <= '0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_x_out     <= '0;
      for (int n = 0; n < N; n++) r_x_mem[n] <= '0;
`ifdef GSIM_EARLY_STOP_EN
      r_changed    <= 1'b0;
      r_iters_used <= '0;
`endif
    end else begin
      case (r_state)
        ST_RECV: begin
          if (in_en) begin
            r_b_mem[r_idx] <= b_in;
            r_busy         <= 1'b1;
            if (r_idx == I_LAST) begin
              r_idx      <= '0;
              r_sweep    <= '0;
              r_phase    <= 1'b0;
              r_in_ready <= 1'b0;
              r_state    <= ST_SOLVE;
`ifdef GSIM_EARLY_STOP_EN
              r_changed  <= 1'b0;
`endif
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        ST_SOLVE: begin
          if (!r_phase) begin
            r_t     <= w_s + C_ROUND;
            r_phase <= 1'b1;
          end else begin
            r_phase        <= 1'b0;
            r_x_mem[r_idx] <= w_x_new;
`ifdef GSIM_EARLY_STOP_EN
            if (w_x_new != r_x_mem[r_idx]) r_changed <= 1'b1;
`endif
            if (r_idx == I_LAST) begin
              r_idx <= '0;
              if (r_sweep == K_LAST || w_converged) begin
                r_state     <= ST_SEND;
                r_out_valid <= 1'b1;
                r_x_out     <= r_x_mem[0];
`ifdef GSIM_EARLY_STOP_EN
                r_iters_used <= r_sweep + 16'd1;
`endif
              end else begin
                r_sweep <= r_sweep + 16'd1;
`ifdef GSIM_EARLY_STOP_EN
                r_changed <= 1'b0;
`endif
              end
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        ST_SEND: begin
          if (out_ready) begin
            if (r_idx == I_LAST) begin
              r_state     <= ST_RECV;
              r_idx       <= '0;
              r_out_valid <= 1'b0;
              r_busy      <= 1'b0;
              r_in_ready  <= 1'b1;
              r_x_out     <= '0;
              for (int n = 0; n < N; n++) r_x_mem[n] <= '0;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_x_out <= r_x_mem[r_idx + 1'b1];
            end
          end
        end
        default: r_state <= ST_RECV;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign x_out     = r_x_out;

endmodule

// File: tb/tb_gsim_band_solver.sv
`timescale 1ns/1ps
// Bench for gsim_band_solver: random b frames checked against a real-valued
// Gauss-Seidel reference model, with stalls, gaps, reset aborts and back-to-back frames.
module tb_gsim_band_solver;
  localparam int N    = 16;
  localparam int BW   = 16;
  localparam int XW   = 32;
  localparam int FRAC = 16;
  localparam int ITER = 70;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset, in_en, out_ready;
  logic signed [BW-1:0] b_in;
  logic                 in_ready, busy, out_valid;
  logic signed [XW-1:0] x_out;
  logic                 reset1, in_en1, out_ready1;
  logic signed [BW-1:0] b_in1;
  logic                 in_ready1, busy1, out_valid1;
  logic signed [XW-1:0] x_out1;
`ifdef GSIM_EARLY_STOP_EN
  logic [15:0] iters_used, iters_used1;
`endif

  gsim_band_solver #(.N(N), .BW(BW), .XW(XW), .FRAC(FRAC), .ITER(ITER)) dut (
    .clk(clk), .reset(reset), .in_en(in_en), .b_in(b_in), .in_ready(in_ready),
    .busy(busy), .out_ready(out_ready), .out_valid(out_valid), .x_out(x_out)
`ifdef GSIM_EARLY_STOP_EN
    , .iters_used(iters_used)
`endif
  );

  gsim_band_solver #(.N(N), .BW(BW), .XW(XW), .FRAC(FRAC), .ITER(1)) dut1 (
    .clk(clk), .reset(reset1), .in_en(in_en1), .b_in(b_in1), .in_ready(in_ready1),
    .busy(busy1), .out_ready(out_ready1), .out_valid(out_valid1), .x_out(x_out1)
`ifdef GSIM_EARLY_STOP_EN
    , .iters_used(iters_used1)
`endif
  );

  int     n_checks = 0;
  int     n_fail   = 0;
  longint b_vec [N];
  longint exp_x [N];
  longint got_x [N];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: x_i = floor((b_i*2^FRAC - sum_{j!=i} A_ij x_j + 10) / 20), saturated, swept in place.
  // All magnitudes stay well below 2^53, so real arithmetic is exact here.
  task automatic model(input int iters);
    real x [N];
    real s, q, cf;
    for (int i = 0; i < N; i++) x[i] = 0.0;
    for (int k = 0; k < iters; k++) begin
      for (int i = 0; i < N; i++) begin
        s = $itor(b_vec[i]) * 65536.0;
        for (int d = -3; d <= 3; d++) begin
          if (d != 0 && i + d >= 0 && i + d < N) begin
            cf = (d == 1 || d == -1) ? 13.0 : ((d == 2 || d == -2) ? -6.0 : 1.0);
            s = s + cf * x[i + d];
          end
        end
        q = $floor((s + 10.0) / 20.0);
        if (q > 2147483647.0) q = 2147483647.0;
        if (q < -2147483648.0) q = -2147483648.0;
        x[i] = q;
      end
    end
    for (int i = 0; i < N; i++) exp_x[i] = longint'(x[i]);
  endtask

  task automatic rand_b(input int mode);
    logic signed [BW-1:0] r;
    for (int i = 0; i < N; i++) begin
      r = BW'($urandom);
      if (mode == 1) r = (i % 2 == 0) ? 16'sh7FFF : 16'sh8000;
      if (mode == 2) r = 16'sh8000;
      if (mode == 3) r = '0;
      b_vec[i] = longint'(r);
    end
  endtask

  task automatic drive_frame(input int max_gap);
    for (int i = 0; i < N; i++) begin
      repeat ($urandom_range(max_gap, 0)) begin
        in_en = 1'b0;
        b_in  = BW'($urandom);
        step();
      end
      in_en = 1'b1;
      b_in  = b_vec[i][BW-1:0];
      step();
    end
    in_en = 1'b0;
  endtask

  // Collects N beats into got_x; counts x_out changes while stalled.
  task automatic recv_frame(input int stall_pct, input bit junk,
                            output int stab_err, output bit timed_out);
    int idx = 0;
    int budget = 0;
    bit held = 1'b0;
    logic signed [XW-1:0] held_val = '0;
    stab_err  = 0;
    timed_out = 1'b0;
    while (idx < N) begin
      if (budget > 8000) begin
        timed_out = 1'b1;
        break;
      end
      out_ready = ($urandom_range(99, 0) >= stall_pct);
      if (junk) begin
        in_en = 1'b1;
        b_in  = BW'($urandom);
      end
      if (out_valid) begin
        if (held && x_out !== held_val) stab_err++;
        if (out_ready) begin
          got_x[idx] = longint'(x_out);
          idx++;
          held = 1'b0;
        end else begin
          held     = 1'b1;
          held_val = x_out;
        end
      end
      step();
      budget++;
    end
    out_ready = 1'b0;
    in_en     = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; reset1 = 1'b1;
    in_en = 1'b0; in_en1 = 1'b0; out_ready = 1'b0; out_ready1 = 1'b0;
    b_in = '0; b_in1 = '0;
    step(); step();
    reset = 1'b0; reset1 = 1'b0;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
    n_checks++; if (x_out !== '0) begin n_fail++; $display("FAIL reset_x_out: got %0h expected 0", x_out); end
    n_checks++; if (in_ready1 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready1: got %0b expected 1", in_ready1); end
    $display("test_reset done");
  endtask

  task automatic test_zero();
    int se; bit to;
    rand_b(3);
    model(ITER);
    drive_frame(0);
    n_checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL zero_solve_flags: got busy=%0b in_ready=%0b expected 1/0", busy, in_ready); end
    recv_frame(0, 1'b0, se, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL zero_timeout: got timeout expected 16 beats"); end
    for (int i = 0; i < N; i++) begin
      n_checks++; if (got_x[i] !== exp_x[i]) begin n_fail++; $display("FAIL zero_x[%0d]: got %0d expected %0d", i, got_x[i], exp_x[i]); end
    end
    n_checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL zero_end_flags: got busy=%0b out_valid=%0b expected 0/0", busy, out_valid); end
    $display("test_zero done: frame of zeros");
  endtask

  task automatic test_iter1();
    int idx = 0;
    int budget = 0;
    rand_b(3);
    b_vec[0] = 20;
    model(1);
    for (int i = 0; i < N; i++) begin
      in_en1 = 1'b1;
      b_in1  = b_vec[i][BW-1:0];
      step();
    end
    in_en1 = 1'b0;
    out_ready1 = 1'b1;
    while (idx < N && budget < 2000) begin
      if (out_valid1) begin
        got_x[idx] = longint'(x_out1);
        idx++;
      end
      step();
      budget++;
    end
    out_ready1 = 1'b0;
    n_checks++; if (idx != N) begin n_fail++; $display("FAIL iter1_beats: got %0d expected %0d", idx, N); end
    n_checks++; if (got_x[0] !== 64'd65536) begin n_fail++; $display("FAIL iter1_x0: got %0d expected 65536", got_x[0]); end
    n_checks++; if (got_x[1] !== 64'd42598) begin n_fail++; $display("FAIL iter1_x1: got %0d expected 42598", got_x[1]); end
    for (int i = 2; i < N; i++) begin
      n_checks++; if (got_x[i] !== exp_x[i]) begin n_fail++; $display("FAIL iter1_x[%0d]: got %0d expected %0d", i, got_x[i], exp_x[i]); end
    end
    $display("test_iter1 done: x0=%0d x1=%0d", got_x[0], got_x[1]);
  endtask

  task automatic test_random_stall();
    int se; bit to;
    for (int f = 0; f < 3; f++) begin
      rand_b(f);
      model(ITER);
      drive_frame(0);
      recv_frame(50, 1'b0, se, to);
      n_checks++; if (to) begin n_fail++; $display("FAIL stall_timeout[%0d]: got timeout expected 16 beats", f); end
      n_checks++; if (se != 0) begin n_fail++; $display("FAIL stall_stability[%0d]: got %0d changes expected 0", f, se); end
      for (int i = 0; i < N; i++) begin
        n_checks++; if (got_x[i] !== exp_x[i]) begin n_fail++; $display("FAIL stall_x[%0d][%0d]: got %0d expected %0d", f, i, got_x[i], exp_x[i]); end
      end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_extra_beat[%0d]: got out_valid=%0b expected 0", f, out_valid); end
      $display("test_random_stall frame %0d done: x0=%0d", f, got_x[0]);
    end
  endtask

  task automatic test_gaps_ignored();
    int se; bit to;
    rand_b(0);
    model(ITER);
    drive_frame(5);
    recv_frame(30, 1'b1, se, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL gaps_timeout: got timeout expected 16 beats"); end
    n_checks++; if (se != 0) begin n_fail++; $display("FAIL gaps_stability: got %0d changes expected 0", se); end
    for (int i = 0; i < N; i++) begin
      n_checks++; if (got_x[i] !== exp_x[i]) begin n_fail++; $display("FAIL gaps_x[%0d]: got %0d expected %0d", i, got_x[i], exp_x[i]); end
    end
    n_checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL gaps_idle: got busy=%0b in_ready=%0b expected 0/1", busy, in_ready); end
    $display("test_gaps_ignored done");
  endtask

  task automatic test_reset_midop();
    int se; bit to;
    int budget = 0;
    rand_b(0);
    drive_frame(0);
    repeat (50) step();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_solve_busy: got %0b expected 1", busy); end
    reset = 1'b1; step(); reset = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_solve_flags: got ov=%0b ir=%0b busy=%0b expected 0/1/0", out_valid, in_ready, busy); end
    drive_frame(0);
    while (!out_valid && budget < 8000) begin step(); budget++; end
    n_checks++; if (!out_valid) begin n_fail++; $display("FAIL rst_send_timeout: got out_valid=0 expected 1"); end
    out_ready = 1'b1;
    repeat (3) step();
    out_ready = 1'b0;
    reset = 1'b1; step(); reset = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_send_flags: got ov=%0b ir=%0b expected 0/1", out_valid, in_ready); end
    rand_b(0);
    model(ITER);
    drive_frame(2);
    recv_frame(20, 1'b0, se, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL rst_after_timeout: got timeout expected 16 beats"); end
    for (int i = 0; i < N; i++) begin
      n_checks++; if (got_x[i] !== exp_x[i]) begin n_fail++; $display("FAIL rst_after_x[%0d]: got %0d expected %0d", i, got_x[i], exp_x[i]); end
    end
    $display("test_reset_midop done");
  endtask

  task automatic test_back_to_back();
    int se; bit to;
    int budget;
    for (int f = 0; f < 4; f++) begin
      rand_b(f == 3 ? 3 : 0);
      model(ITER);
      drive_frame(0);
      budget = 0;
      while (!out_valid && budget < 8000) begin step(); budget++; end
`ifdef GSIM_EARLY_STOP_EN
      if (f == 3) begin
        n_checks++; if (iters_used !== 16'd1) begin n_fail++; $display("FAIL b2b_iters_used: got %0d expected 1", iters_used); end
      end
`endif
      recv_frame(25, 1'b0, se, to);
      n_checks++; if (to) begin n_fail++; $display("FAIL b2b_timeout[%0d]: got timeout expected 16 beats", f); end
      for (int i = 0; i < N; i++) begin
        n_checks++; if (got_x[i] !== exp_x[i]) begin n_fail++; $display("FAIL b2b_x[%0d][%0d]: got %0d expected %0d", f, i, got_x[i], exp_x[i]); end
      end
      $display("test_back_to_back frame %0d done: x0=%0d", f, got_x[0]);
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_iter1();
    test_random_stall();
    test_gaps_ignored();
    test_reset_midop();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got no completion expected summary before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
